// File: rtl/regfile_mp.sv
// Multi-port register file: two read ports plus a debug read port, ALU and load write ports,
// a pending-load scoreboard and a clear sequencer. Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read bypass.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | normal operation; clr_req starts a clear sequence
// S_CLEAR | zero rf[idx] and pend[idx] each cycle, idx = 0 .. NREGS-2
// S_DONE  | one-cycle clr_done pulse, then back to S_IDLE
module regfile_mp #(
   parameter int DW    = 32,
   parameter int NREGS = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic [AW-1:0] db_addr,
   output logic [DW-1:0] db_data,
   input  logic [DW-1:0] pc_in,
   input  logic          we0,
   input  logic [AW-1:0] wa0,
   input  logic [DW-1:0] wd0,
   input  logic          we1,
   input  logic [AW-1:0] wa1,
   input  logic [DW-1:0] wd1,
   input  logic          pend_set,
   input  logic [AW-1:0] pend_addr,
   output logic          pend1,
   output logic          pend2,
   output logic          pend_any,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done
);

   localparam int NST = NREGS - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_q;
   logic [AW-1:0]   idx_q;
   logic            clr_busy_q;
   logic            clr_done_q;

   logic [DW-1:0]   rf_q [NST];
   logic [NST-1:0]  pend_q;

   logic            wr0_ok;
   logic            wr1_ok;
   logic            pset_ok;
   logic            clr_wr;

   function automatic logic in_store(input logic [AW-1:0] a);
      return int'(a) < NST;
   endfunction

   // Front-end requests are locked out for the whole clear sequence, including the DONE cycle.
   always_comb begin
      wr0_ok  = we0      && !clr_busy_q && in_store(wa0);
      wr1_ok  = we1      && !clr_busy_q && in_store(wa1);
      pset_ok = pend_set && !clr_busy_q && in_store(pend_addr);
      clr_wr  = (state_q == S_CLEAR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               clr_done_q <= 1'b0;
               if (clr_req) begin
                  state_q    <= S_CLEAR;
                  idx_q      <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (int'(idx_q) == NST - 1) begin
                  state_q    <= S_DONE;
                  clr_done_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q    <= S_IDLE;
               clr_busy_q <= 1'b0;
               clr_done_q <= 1'b0;
            end
            default: begin
               state_q    <= S_IDLE;
               clr_busy_q <= 1'b0;
               clr_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Port 1 overrides port 0 on a collision; a pend_set overrides a same-cycle load clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NST; i++) begin
            rf_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         for (int i = 0; i < NST; i++) begin
            if (clr_wr) begin
               if (int'(idx_q) == i) begin
                  rf_q[i]   <= '0;
                  pend_q[i] <= 1'b0;
               end
            end else begin
               if (wr1_ok && int'(wa1) == i) begin
                  rf_q[i] <= wd1;
               end else if (wr0_ok && int'(wa0) == i) begin
                  rf_q[i] <= wd0;
               end
               if (pset_ok && int'(pend_addr) == i) begin
                  pend_q[i] <= 1'b1;
               end else if (wr1_ok && int'(wa1) == i) begin
                  pend_q[i] <= 1'b0;
               end
            end
         end
      end
   end

   function automatic logic [DW-1:0] rd_mux(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = '0;
      if (int'(a) == NREGS - 1) begin
         v = pc_in;
      end else begin
         for (int i = 0; i < NST; i++) begin
            if (int'(a) == i) begin
               v = rf_q[i];
            end
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr1_ok && wa1 == a) begin
         v = wd1;
      end else if (wr0_ok && wa0 == a) begin
         v = wd0;
      end
`endif
      return v;
   endfunction

   function automatic logic pend_mux(input logic [AW-1:0] a);
      logic p;
      p = 1'b0;
      for (int i = 0; i < NST; i++) begin
         if (int'(a) == i) begin
            p = pend_q[i];
         end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr1_ok && wa1 == a && !(pset_ok && pend_addr == a)) begin
         p = 1'b0;
      end
`endif
      return p;
   endfunction

   always_comb begin
      rd1      = rd_mux(ra1);
      rd2      = rd_mux(ra2);
      db_data  = rd_mux(db_addr);
      pend1    = pend_mux(ra1);
      pend2    = pend_mux(ra2);
      pend_any = |pend_q;
   end

   assign clr_busy = clr_busy_q;
   assign clr_done = clr_done_q;

endmodule
